// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR pseudo-random source with a bounded-draw port.
//
// The LFSR free-runs on en_i, can be seeded through load_i/load_val_i, and is
// prevented from locking up at zero. A requester can also ask for a uniform-ish
// value in [0, limit) over a valid/ready handshake. The value is found by masked
// rejection sampling with a bounded number of attempts and a fallback.
//
// Ports
//   clk_i         system clock, rising edge
//   preset_ni     synchronous active-low reset
//   en_i          free-run step enable (honoured in IDLE only)
//   load_i        load load_val_i into the state this edge (zero loads SEED)
//   load_val_i    seed value to load
//   state_o       current LFSR state
//   draw_req_i    draw request, sampled while draw_ready_o is high
//   draw_limit_i  exclusive upper bound of the draw; 0 means 2^OUT_W
//   draw_ready_o  high in IDLE
//   draw_valid_o  one-cycle pulse marking a fresh draw_val_o
//   draw_val_o    draw result, held until the next result
//   draw_tries_o  attempts used by the last draw (1..MAX_TRIES)
module lfsr_rng #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk_i,
    input  logic             preset_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o,
    input  logic             draw_req_i,
    input  logic [OUT_W-1:0] draw_limit_i,
    output logic             draw_ready_o,
    output logic             draw_valid_o,
    output logic [OUT_W-1:0] draw_val_o,
    output logic [2:0]       draw_tries_o
);

    // One extra bit so a limit of 2^OUT_W is representable.
    localparam int unsigned LIM_W = OUT_W + 1;

    typedef enum logic [0:0] {StIdle, StDraw} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [LIM_W-1:0] limit_q, limit_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [2:0]       tries_q, tries_d;
    logic [OUT_W-1:0] val_q, val_d;
    logic [2:0]       used_q, used_d;
    logic             valid_q, valid_d;

    logic [LIM_W-1:0] lim_in;
    logic [OUT_W-1:0] lim_m1;
    logic [OUT_W-1:0] mask_in;
    logic             fb;
    logic [WIDTH-1:0] state_step;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;
    logic [OUT_W-1:0] fallback;
    logic             last_try;
    logic             step_en;

    // Mask is the smallest all-ones value covering L-1, i.e. 2^ceil(log2 L) - 1.
    always_comb begin
        lim_in  = (draw_limit_i == '0) ? (LIM_W'(1) << OUT_W) : {1'b0, draw_limit_i};
        lim_m1  = OUT_W'(lim_in - LIM_W'(1));
        mask_in = lim_m1;
        for (int k = 1; k < int'(OUT_W); k++) begin
            mask_in = mask_in | (lim_m1 >> k);
        end
    end

    assign fb         = ^(state_q & TAPS);
    assign state_step = {state_q[WIDTH-2:0], fb};

    // Candidate is taken from the pre-step state. Since M < 2L, c - L < L on fallback.
    assign cand     = state_q[OUT_W-1:0] & mask_q;
    assign cand_ok  = ({1'b0, cand} < limit_q);
    assign fallback = OUT_W'({1'b0, cand} - limit_q);
    assign last_try = (tries_q == 3'(MAX_TRIES));

    always_comb begin
        fsm_d   = fsm_q;
        limit_d = limit_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        val_d   = val_q;
        used_d  = used_q;
        valid_d = 1'b0;
        step_en = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                step_en = en_i;
                if (draw_req_i) begin
                    limit_d = lim_in;
                    mask_d  = mask_in;
                    tries_d = 3'd1;
                    fsm_d   = StDraw;
                end
            end
            StDraw: begin
                step_en = 1'b1;
                if (cand_ok || last_try) begin
                    val_d   = cand_ok ? cand : fallback;
                    used_d  = tries_q;
                    valid_d = 1'b1;
                    fsm_d   = StIdle;
                end else begin
                    tries_d = tries_q + 3'd1;
                end
            end
        endcase

        // Load beats stepping; a zero state (or zero load) falls back to SEED.
        state_d = state_q;
        if (load_i) begin
            state_d = (load_val_i == '0) ? SEED : load_val_i;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (step_en) begin
            state_d = state_step;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!preset_ni) begin
            fsm_q   <= StIdle;
            state_q <= SEED;
            limit_q <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            val_q   <= '0;
            used_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            limit_q <= limit_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            val_q   <= val_d;
            used_q  <= used_d;
            valid_q <= valid_d;
        end
    end

    assign state_o      = state_q;
    assign draw_ready_o = (fsm_q == StIdle);
    assign draw_valid_o = valid_q;
    assign draw_val_o   = val_q;
    assign draw_tries_o = used_q;

endmodule
